// File: rtl/matrix_pkg.sv
// Shared constants, size encodings, fill FSM states and element addressing
// for the 4x4 matrix loader.
package matrix_pkg;

    localparam int ELEM_W = 8;
    localparam int N      = 4;
    localparam int MAT_W  = N * N * ELEM_W;

    localparam logic [1:0] SZ_1X1 = 2'd0;
    localparam logic [1:0] SZ_2X2 = 2'd1;
    localparam logic [1:0] SZ_3X3 = 2'd2;
    localparam logic [1:0] SZ_4X4 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } fill_state_e;

    // LSB position of element (r,c); (0,0) is the most significant byte.
    // 8*(15 - (4r+c)) reduces to the inverted row/col index shifted by 3.
    function automatic logic [6:0] elem_lsb(input logic [1:0] r, input logic [1:0] c);
        return {~r, ~c, 3'b000};
    endfunction

endpackage

// File: rtl/matrix_pad_gen.sv
// Identity-padding image for a matrix of dimension size+1: ones on the
// diagonal beyond the used region, zeros everywhere else.
module matrix_pad_gen
    import matrix_pkg::*;
(
    input  logic [1:0]       size,
    output logic [MAT_W-1:0] pad
);

    // Build the padded image one diagonal element at a time.
    always_comb begin
        pad = '0;
        for (int k = 0; k < N; k++) begin
            if (2'(k) > size) begin
                pad[elem_lsb(2'(k), 2'(k)) +: ELEM_W] = 8'h01;
            end else begin
                pad[elem_lsb(2'(k), 2'(k)) +: ELEM_W] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// Serial element stream to packed 4x4 matrix, with a fill register and an
// output register so one matrix can drain while the next one fills.
module matrix_loader
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    input  logic [1:0]        in_size,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MAT_W-1:0]  out_matrix,
    output logic [1:0]        out_size
);

    fill_state_e      state_r, state_nxt_s;
    logic [1:0]       row_r, col_r, row_nxt_s, col_nxt_s;
    logic [1:0]       size_r, size_nxt_s, cur_size_s;
    logic [MAT_W-1:0] fill_r, fill_nxt_s, fill_base_s, fill_wr_s, pad_s;
    logic             in_ready_r, out_valid_r;
    logic [MAT_W-1:0] out_matrix_r, load_mat_s;
    logic [1:0]       out_size_r, load_size_s;
    logic             accept_s, out_free_s, last_s, load_out_s;

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_matrix = out_matrix_r;
    assign out_size   = out_size_r;

    assign accept_s   = in_valid && in_ready_r && !abort;
    assign out_free_s = !out_valid_r || out_ready;

    matrix_pad_gen u_pad (
        .size (in_size),
        .pad  (pad_s)
    );

    // Size and base image: the first element of a matrix starts from the
    // padding image and its own size code, later elements from the fill register.
    always_comb begin
        cur_size_s  = size_r;
        fill_base_s = fill_r;
        if (state_r == IDLE) begin
            cur_size_s  = in_size;
            fill_base_s = pad_s;
        end else begin
            cur_size_s  = size_r;
            fill_base_s = fill_r;
        end
        fill_wr_s = fill_base_s;
        fill_wr_s[elem_lsb(row_r, col_r) +: ELEM_W] = in_data;
        last_s = (row_r == cur_size_s) && (col_r == cur_size_s);
    end

    // Fill FSM next state, counters and output-register load decision.
    always_comb begin
        state_nxt_s = state_r;
        row_nxt_s   = row_r;
        col_nxt_s   = col_r;
        size_nxt_s  = size_r;
        fill_nxt_s  = fill_r;
        load_out_s  = 1'b0;
        load_mat_s  = fill_r;
        load_size_s = size_r;
        if (abort) begin
            state_nxt_s = IDLE;
            row_nxt_s   = 2'd0;
            col_nxt_s   = 2'd0;
        end else begin
            case (state_r)
                IDLE, FILL: begin
                    if (accept_s) begin
                        size_nxt_s = cur_size_s;
                        fill_nxt_s = fill_wr_s;
                        if (last_s) begin
                            row_nxt_s = 2'd0;
                            col_nxt_s = 2'd0;
                            if (out_free_s) begin
                                load_out_s  = 1'b1;
                                load_mat_s  = fill_wr_s;
                                load_size_s = cur_size_s;
                                state_nxt_s = IDLE;
                            end else begin
                                state_nxt_s = FULL;
                            end
                        end else begin
                            state_nxt_s = FILL;
                            if (col_r == cur_size_s) begin
                                col_nxt_s = 2'd0;
                                row_nxt_s = row_r + 2'd1;
                            end else begin
                                col_nxt_s = col_r + 2'd1;
                            end
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                FULL: begin
                    if (out_free_s) begin
                        load_out_s  = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    row_nxt_s   = 2'd0;
                    col_nxt_s   = 2'd0;
                end
            endcase
        end
    end

    // Fill-side state registers; in_ready follows the registered FSM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            row_r      <= 2'd0;
            col_r      <= 2'd0;
            size_r     <= 2'd0;
            fill_r     <= '0;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            row_r      <= row_nxt_s;
            col_r      <= col_nxt_s;
            size_r     <= size_nxt_s;
            fill_r     <= fill_nxt_s;
            in_ready_r <= (state_nxt_s != FULL);
        end
    end

    // Output register: load a completed matrix, or drop valid once taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r  <= 1'b0;
            out_matrix_r <= '0;
            out_size_r   <= 2'd0;
        end else if (load_out_s) begin
            out_valid_r  <= 1'b1;
            out_matrix_r <= load_mat_s;
            out_size_r   <= load_size_s;
        end else if (out_ready) begin
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

endmodule
